// File: rtl/pulse_counter_n.sv
// Pulse counter: counts synchronized rising edges of an asynchronous input down from a
// loadable period, emitting a one-cycle pulse at each period completion. Supports periodic
// reload and one-shot operation, and tracks how many periods have completed.
module pulse_counter_n #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WRAP_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_pulse,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      start,
  input  logic                  mode,
  output logic                  out_pulse,
  output logic [WIDTH-1:0]      pos_value,
  output logic                  busy,
  output logic [WRAP_WIDTH-1:0] wrap_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WIDTH-1:0]      CountOne = WIDTH'(1);
  localparam logic [WRAP_WIDTH-1:0] WrapOne  = WRAP_WIDTH'(1);

  logic sync1_q, sync2_q, hist_q;
  logic tick;

  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic                  mode_q, mode_d;
  logic [WRAP_WIDTH-1:0] wrap_q, wrap_d;
  logic                  out_q, out_d;

  // Synchronize the async input and keep one flop of history for rising-edge detection.
  // Reset to 1 so an input held high through reset release is not seen as an edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= in_pulse;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~hist_q;

  // Next-state logic: load wins over a coincident tick, which is then dropped.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    wrap_d   = wrap_q;
    out_d    = 1'b0;
    if (load) begin
      period_d = start;
      count_d  = start;
      mode_d   = mode;
      wrap_d   = '0;
      state_d  = (start != '0) ? StRun : StIdle;
    end else if ((state_q == StRun) && tick && enable) begin
      if (count_q > CountOne) begin
        count_d = count_q - CountOne;
      end else begin
        out_d  = 1'b1;
        wrap_d = wrap_q + WrapOne;
        if (mode_q) begin
          count_d = '0;
          state_d = StDone;
        end else begin
          count_d = period_q;
        end
      end
    end
  end

  // Counter state registers; reset abandons any period in flight without a pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      wrap_q   <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      wrap_q   <= wrap_d;
      out_q    <= out_d;
    end
  end

  assign out_pulse  = out_q;
  assign pos_value  = count_q;
  assign busy       = (state_q == StRun);
  assign wrap_count = wrap_q;

endmodule
